// File: rtl/mux2_sel_arbiter.sv
// Two-requester round-robin arbiter driving the registered select of a 2:1 mux.
// Optional grant statistics counters are enabled by defining MUX2_ARB_STATS_EN.
`default_nettype none

module mux2_sel_arbiter #(
   parameter int HOLD_MAX = 16,
   parameter int CNT_W    = 8
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             req_a,
   input  logic             req_b,
   input  logic             done_a,
   input  logic             done_b,
   output logic             sel,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             busy
`ifdef MUX2_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0] gnt_cnt_a,
   output logic [CNT_W-1:0] gnt_cnt_b
`endif
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic             last_q, last_d;   // 0: A owned last, 1: B owned last
   logic             sel_q, sel_d;
   logic             gnt_a_q, gnt_b_q, busy_q;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      hold_d  = hold_q;
      sel_d   = sel_q;

      case (state_q)
         IDLE: begin
            if (req_a && req_b)  state_d = last_q ? OWN_A : OWN_B;
            else if (req_a)      state_d = OWN_A;
            else if (req_b)      state_d = OWN_B;
         end
         OWN_A: begin
            if (done_a) begin
               state_d = IDLE;
               last_d  = 1'b0;
            end else if (req_b && (hold_q == HOLD_LAST)) begin
               state_d = OWN_B;
               last_d  = 1'b0;
            end
         end
         OWN_B: begin
            if (done_b) begin
               state_d = IDLE;
               last_d  = 1'b1;
            end else if (req_a && (hold_q == HOLD_LAST)) begin
               state_d = OWN_A;
               last_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Count only contested cycles; an uncontested owner keeps its tally.
      if (state_d != state_q)
         hold_d = '0;
      else if ((state_q == OWN_A && req_b) || (state_q == OWN_B && req_a))
         hold_d = hold_q + 1'b1;

      if (state_d == OWN_A)      sel_d = 1'b0;
      else if (state_d == OWN_B) sel_d = 1'b1;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         hold_q  <= '0;
         last_q  <= 1'b1;
         sel_q   <= 1'b0;
         gnt_a_q <= 1'b0;
         gnt_b_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         last_q  <= last_d;
         sel_q   <= sel_d;
         gnt_a_q <= (state_d == OWN_A);
         gnt_b_q <= (state_d == OWN_B);
         busy_q  <= (state_d != IDLE);
      end
   end

   assign sel   = sel_q;
   assign gnt_a = gnt_a_q;
   assign gnt_b = gnt_b_q;
   assign busy  = busy_q;

`ifdef MUX2_ARB_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
   logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

   always_comb begin
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      if (state_d == OWN_A && state_q != OWN_A && cnt_a_q != CNT_MAX)
         cnt_a_d = cnt_a_q + 1'b1;
      if (state_d == OWN_B && state_q != OWN_B && cnt_b_q != CNT_MAX)
         cnt_b_d = cnt_b_q + 1'b1;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cnt_a_q <= '0;
         cnt_b_q <= '0;
      end else begin
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
      end
   end

   assign gnt_cnt_a = cnt_a_q;
   assign gnt_cnt_b = cnt_b_q;
`endif

endmodule

`default_nettype wire
